regfile_wb_scheduler: RTL
=========================

// Module: regfile_wb_scheduler
// PURPOSE
// Shares the single register-file write port (scalar + vector files) among three writeback sources:
// scalar ALU, vector ALU and load unit. Round-robin arbitration; one registered write per cycle.
// Keeps a per-register pending scoreboard so decode stalls on RAW/WAW hazards.
// Sits between the execute/memory stages and the register file.
// PARAMETERS
// registerSize      8  bits per element
// registerQuantity  8  registers per file (scalar and vector); index width RW = $clog2(registerQuantity)
// vecSize           4  elements per vector word
// PORTS
// clk          in   1                      clock, rising edge
// reset        in   1                      synchronous, active-low
// srcValid     in   3                      per source [0]=scalar ALU [1]=vector ALU [2]=load
// srcReady     out  3                      grant; handshake = srcValid[i] & srcReady[i]
// srcIsVec     in   3                      target file per source (1 = vector file)
// srcReg       in   3 x RW                 destination index per source
// srcData      in   3 x vecSize x regSize  writeback data per source
// issueValid   in   1                      decode issues an instruction this cycle
// issueWrites  in   1                      issued instruction has a destination
// issueIsVec   in   1                      destination file of issued instruction
// issueReg     in   RW                     destination index of issued instruction
// rSel1, rSel2 in   4                      decode sources; bit3 = vector file, [2:0] = index
// stall        out  1                      decode must hold; issueValid ignored while high
// regWrEnSc    out  1                      registered scalar write enable
// regWrEnVec   out  1                      registered vector write enable
// regToWrite   out  RW                     registered write index
// dataIn       out  vecSize x regSize      registered write data (scalar file uses element 0)
// BEHAVIOUR
// - Reset (reset==0 at posedge): regWrEnSc = regWrEnVec = 0, regToWrite = 0, dataIn = 0,
//   all pending bits = 0, rrPtr = 0. srcReady = 0 and stall = 0 while reset is low.
// - Arbitration (comb): search order starts at rrPtr, wraps 0..2. At most one srcReady bit is high,
//   and only for a valid source. No valid source -> srcReady = 0, rrPtr unchanged.
// - On a handshake from source g: rrPtr <= (g+1) mod 3.
// - Write stage (registered): the next cycle after a handshake, regWrEnVec = srcIsVec[g],
//   regWrEnSc = !srcIsVec[g], with regToWrite and dataIn from source g. Otherwise both enables are 0;
//   regToWrite and dataIn hold. Latency is exactly 1 cycle; there is no backpressure from the file.
// - Scoreboard: pendSc[RQ], pendVec[RQ].
//   - Set on issueValid & issueWrites & !stall for (issueIsVec, issueReg).
//   - Cleared in the cycle the registered write is presented: the bit is 0 from the following cycle.
//   - Set and clear of the same bit in the same cycle: set wins, because the new reservation is younger.
// - stall (comb) is high when any of these holds:
//   - pend[rSel1];
//   - pend[rSel2];
//   - issueWrites & pend[issueIsVec, issueReg] (WAW).
//   Bypass: a bit being cleared this cycle counts as not pending.
// - Sources must hold valid and payload stable until granted. A source dropping valid before its
//   grant is a protocol error; the bench asserts against it.
// - A writeback to a non-pending register is still written. The bit stays 0 and no error is flagged.
// - Reset mid-operation: the in-flight registered write is discarded (enables forced 0) and the
//   scoreboard is cleared.
// STRUCTURE
// - Package regfile_pkg: wb_src_e {SRC_SC_ALU, SRC_VEC_ALU, SRC_LOAD}, NUM_WB_SRC = 3,
//   RW localparam function, typedef wb_req_t {isVec, reg, data}.
// - Sub-module rr_arbiter #(N=3): req, advance -> onehot grant, ptr. Reused elsewhere.
// - Top: arbiter instance, payload mux, write-stage flops, scoreboard, stall logic.
// TESTING
// 1. Reset: hold reset=0 for 2 cycles with all srcValid=1 -> srcReady=0, enables 0, stall 0, pend all 0.
// 2. Contention: all three valid continuously, rrPtr=0 -> grants 0,1,2,0 on consecutive cycles;
//    write enables follow one cycle later, with file and index matching each source.
// 3. RAW: issue writes scalar r3; next cycle rSel1=4'b0011 -> stall=1 until scalar ALU writes r3;
//    stall=0 in the write-present cycle (bypass).
// 4. WAW / set-clear collision: vector r5 pending; load writes v5 while decode issues a new write to v5
//    in the same cycle -> pendVec[5] stays 1.
// 5. Idle: no valid sources -> srcReady=0, enables 0, rrPtr unchanged, dataIn holds previous value.
// 6. Mid-operation reset: handshake in cycle N, reset=0 at cycle N+1 -> no write enable asserted,
//    scoreboard cleared.

Source files
------------

// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared types and sizing for the register-file writeback scheduler.
package regfile_pkg;

    typedef enum logic [1:0] {
        SRC_SC_ALU  = 2'd0,
        SRC_VEC_ALU = 2'd1,
        SRC_LOAD    = 2'd2
    } wb_src_e;

    localparam int NUM_WB_SRC = 3;
    localparam int REG_SIZE   = 8;
    localparam int REG_QTY    = 8;
    localparam int VEC_SIZE   = 4;

    function automatic int idxWidth(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int RW = idxWidth(REG_QTY);

    typedef struct packed {
        logic                                isVec;
        logic [RW-1:0]                       regIdx;
        logic [VEC_SIZE-1:0][REG_SIZE-1:0]   data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from ptr upward with wrap;
// ptr moves just past the winner only when the caller reports a completed handshake.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = (N <= 1) ? 1 : $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] ptr
);

    localparam int SW = PW + 1;

    logic [SW-1:0] sum;
    logic [PW-1:0] idx;
    logic [PW-1:0] gIdx;
    logic [PW-1:0] nextPtr;

    always_comb begin
        grant = '0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + SW'(k);
            idx = (sum >= SW'(N)) ? PW'(sum - SW'(N)) : sum[PW-1:0];
            if (grant == '0 && req[idx]) begin
                grant[idx] = 1'b1;
            end
        end
    end

    always_comb begin
        gIdx = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                gIdx = PW'(i);
            end
        end
        nextPtr = (gIdx == PW'(N - 1)) ? '0 : gIdx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr <= '0;
        end else if (advance && (|grant)) begin
            ptr <= nextPtr;
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Arbitrates three writeback sources onto the single register-file write port
// and tracks outstanding destinations so decode can stall on RAW/WAW hazards.
module regfile_wb_scheduler
    import regfile_pkg::*;
#(
    parameter int registerSize     = REG_SIZE,
    parameter int registerQuantity = REG_QTY,
    parameter int vecSize          = VEC_SIZE,
    localparam int RWL             = idxWidth(registerQuantity)
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic [NUM_WB_SRC-1:0]                             srcValid,
    output logic [NUM_WB_SRC-1:0]                             srcReady,
    input  logic [NUM_WB_SRC-1:0]                             srcIsVec,
    input  logic [NUM_WB_SRC-1:0][RWL-1:0]                    srcReg,
    input  logic [NUM_WB_SRC-1:0][vecSize-1:0][registerSize-1:0] srcData,
    input  logic                                              issueValid,
    input  logic                                              issueWrites,
    input  logic                                              issueIsVec,
    input  logic [RWL-1:0]                                    issueReg,
    input  logic [3:0]                                        rSel1,
    input  logic [3:0]                                        rSel2,
    output logic                                              stall,
    output logic                                              regWrEnSc,
    output logic                                              regWrEnVec,
    output logic [RWL-1:0]                                    regToWrite,
    output logic [vecSize-1:0][registerSize-1:0]              dataIn
);

    localparam int PTRW = idxWidth(NUM_WB_SRC);

    logic [NUM_WB_SRC-1:0] grant;
    logic [PTRW-1:0]       rrPtr;
    logic                  unusedPtr;
    logic                  handshake;
    wb_req_t               selReq;

    logic wrScQ, wrVecQ;

    logic [registerQuantity-1:0] pendSc, pendVec;
    logic [registerQuantity-1:0] clrSc, clrVec, setSc, setVec, effSc, effVec;
    logic                        pend1, pend2, wawHit, doSet;

    // Arbiter pointer is kept only for debug visibility.
    assign unusedPtr = ^rrPtr;

    rr_arbiter #(.N(NUM_WB_SRC)) uArb (
        .clk     (clk),
        .reset   (reset),
        .req     (srcValid),
        .advance (handshake),
        .grant   (grant),
        .ptr     (rrPtr)
    );

    assign srcReady  = reset ? grant : '0;
    assign handshake = |srcReady;

    always_comb begin
        selReq = '0;
        for (int i = 0; i < NUM_WB_SRC; i++) begin
            if (grant[i]) begin
                selReq.isVec  = srcIsVec[i];
                selReq.regIdx = srcReg[i];
                selReq.data   = srcData[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wrScQ      <= 1'b0;
            wrVecQ     <= 1'b0;
            regToWrite <= '0;
            dataIn     <= '0;
        end else if (handshake) begin
            wrScQ      <= ~selReq.isVec;
            wrVecQ     <= selReq.isVec;
            regToWrite <= selReq.regIdx;
            dataIn     <= selReq.data;
        end else begin
            wrScQ      <= 1'b0;
            wrVecQ     <= 1'b0;
        end
    end

    // A write already registered when reset drops must never reach the file.
    assign regWrEnSc  = wrScQ & reset;
    assign regWrEnVec = wrVecQ & reset;

    always_comb begin
        clrSc  = '0;
        clrVec = '0;
        clrSc[regToWrite]  = regWrEnSc;
        clrVec[regToWrite] = regWrEnVec;
        effSc  = pendSc & ~clrSc;
        effVec = pendVec & ~clrVec;
    end

    // Hazard check sees the bit being retired this cycle as already free.
    always_comb begin
        pend1  = rSel1[3] ? effVec[rSel1[RWL-1:0]] : effSc[rSel1[RWL-1:0]];
        pend2  = rSel2[3] ? effVec[rSel2[RWL-1:0]] : effSc[rSel2[RWL-1:0]];
        wawHit = issueIsVec ? effVec[issueReg] : effSc[issueReg];
        stall  = reset & (pend1 | pend2 | (issueWrites & wawHit));
    end

    always_comb begin
        doSet  = issueValid & issueWrites & ~stall;
        setSc  = '0;
        setVec = '0;
        setSc[issueReg]  = doSet & ~issueIsVec;
        setVec[issueReg] = doSet & issueIsVec;
    end

    // OR-ing the set after the clear lets a same-cycle reissue keep the bit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pendSc  <= '0;
            pendVec <= '0;
        end else begin
            pendSc  <= effSc | setSc;
            pendVec <= effVec | setVec;
        end
    end

endmodule
